potential_adder_threshold: RTL and testbench

- Producer side of the neuron update loop.
- Loads the decayed membrane potential once per timestep and accumulates incoming FP32 synaptic weights onto it through a valid/ready stream.
- At end of timestep, compares the accumulated potential against the firing threshold, emits a spike, and returns the new potential (reset value if fired) to the decay stage.

---
 rtl/potential_adder_threshold_if.sv | 33 +++
 rtl/potential_adder_threshold.sv | 170 +++++++++++++++++
 tb/tb_potential_adder_threshold.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/potential_adder_threshold_if.sv
// Stream/strobe bundle between the decay stage, the synapse feed and the
// potential adder. The slave side is the adder block itself.
interface potential_adder_threshold_if #(
  parameter int MAX_INPUTS = 16
);
  localparam int CNT_W = $clog2(MAX_INPUTS) + 1;

  logic             decay_valid;
  logic [31:0]      decayed_potential;
  logic             weight_valid;
  logic [31:0]      weight;
  logic             weight_ready;
  logic             step_end;
  logic [31:0]      new_potential;
  logic             new_potential_valid;
  logic             spike;
  logic [CNT_W-1:0] input_count;
  logic             busy;
  logic             fp_exception;
  logic             protocol_err;

  modport slave (
    input  decay_valid, decayed_potential, weight_valid, weight, step_end,
    output weight_ready, new_potential, new_potential_valid, spike,
           input_count, busy, fp_exception, protocol_err
  );

  modport master (
    output decay_valid, decayed_potential, weight_valid, weight, step_end,
    input  weight_ready, new_potential, new_potential_valid, spike,
           input_count, busy, fp_exception, protocol_err
  );
endinterface

// File: rtl/potential_adder_threshold.sv
// Neuron potential accumulator: loads the decayed potential, sums FP32
// synaptic weights onto it, then thresholds and returns the new potential.
module potential_adder_threshold #(
  parameter logic [31:0] THRESHOLD  = 32'h41F00000,
  parameter logic [31:0] V_RESET    = 32'h00000000,
  parameter int          MAX_INPUTS = 16
) (
  input logic CLK,
  input logic RST,
  potential_adder_threshold_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_INPUTS) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE} state_t;

  // Combinational FP32 add, round-to-nearest-even, subnormals kept.
  // Returns {exception, result}; exception flags NaN/Inf inputs or overflow.
  function automatic logic [32:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic        sa, sb, nan_a, nan_b, inf_a, inf_b, st, rnd;
    logic [7:0]  ea, eb, d;
    logic [26:0] xa, xb;
    logic [27:0] sum;
    logic [9:0]  ex;
    logic [24:0] rm;
    nan_a = (a_in[30:23] == 8'hFF) && (a_in[22:0] != 23'd0);
    nan_b = (b_in[30:23] == 8'hFF) && (b_in[22:0] != 23'd0);
    inf_a = (a_in[30:23] == 8'hFF) && (a_in[22:0] == 23'd0);
    inf_b = (b_in[30:23] == 8'hFF) && (b_in[22:0] == 23'd0);
    if (nan_a || nan_b || (inf_a && inf_b && (a_in[31] != b_in[31])))
      return {1'b1, 32'h7FC00000};
    if (inf_a) return {1'b1, a_in};
    if (inf_b) return {1'b1, b_in};
    // Larger magnitude goes to a so the alignment shift is always on b
    if (b_in[30:0] > a_in[30:0]) begin a = b_in; b = a_in; end
    else begin a = a_in; b = b_in; end
    sa = a[31];
    sb = b[31];
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    xa = {(a[30:23] != 8'd0), a[22:0], 3'b000};
    xb = {(b[30:23] != 8'd0), b[22:0], 3'b000};
    d  = ea - eb;
    st = 1'b0;
    if (d >= 8'd27) begin
      xb = {26'd0, |xb};
    end else begin
      for (int i = 0; i < 27; i++)
        if (i < int'(d)) st = st | xb[i];
      xb = xb >> d;
      xb[0] = xb[0] | st;
    end
    sum = (sa == sb) ? ({1'b0, xa} + {1'b0, xb}) : ({1'b0, xa} - {1'b0, xb});
    ex  = {2'b00, ea};
    if (sum == 28'd0)
      return {1'b0, ((sa == sb) ? sa : 1'b0), 31'd0};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      ex  = ex + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (!sum[26] && (ex > 10'd1)) begin
          sum = sum << 1;
          ex  = ex - 10'd1;
        end
    end
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    rm  = {1'b0, sum[26:3]} + 25'(rnd);
    if (rm[24]) begin
      rm = rm >> 1;
      ex = ex + 10'd1;
    end
    if (ex >= 10'd255)
      return {1'b1, sa, 8'hFF, 23'd0};
    return {1'b0, sa, (rm[23] ? ex[7:0] : 8'd0), rm[22:0]};
  endfunction

  // Sign-magnitude a >= b; any NaN gives 0, +0 and -0 are equal.
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    if (((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) ||
        ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)))
      return 1'b0;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b1;
    if (a[31] != b[31]) return ~a[31];
    if (!a[31]) return a[30:0] >= b[30:0];
    return a[30:0] <= b[30:0];
  endfunction

  state_t           r_state, w_next;
  logic [31:0]      r_acc, r_np;
  logic [CNT_W-1:0] r_cnt;
  logic             r_npv, r_spike, r_fpx, r_perr;
  logic             w_ready, w_xfer, w_perr_set, w_fire;
  logic [32:0]      w_add;

  assign w_add  = fp_add(r_acc, bus.weight);
  assign w_fire = fp_ge(r_acc, THRESHOLD);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, stream handshake and protocol-violation detection
  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_xfer     = 1'b0;
    w_perr_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.decay_valid) w_next = ACCUM;
        if (bus.step_end)    w_perr_set = 1'b1;
      end
      ACCUM: begin
        w_ready = (r_cnt < MAX_CNT);
        w_xfer  = w_ready && bus.weight_valid;
        if (bus.step_end)    w_next = COMPARE;
        if (bus.decay_valid) w_perr_set = 1'b1;
      end
      COMPARE: begin
        w_next = IDLE;
        if (bus.decay_valid) w_perr_set = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Accumulator, count, result strobes and sticky flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc   <= 32'd0;
      r_np    <= 32'd0;
      r_cnt   <= '0;
      r_npv   <= 1'b0;
      r_spike <= 1'b0;
      r_fpx   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_npv   <= 1'b0;
      r_spike <= 1'b0;
      if (w_perr_set) r_perr <= 1'b1;
      if ((r_state == IDLE) && bus.decay_valid) begin
        r_acc <= bus.decayed_potential;
        r_cnt <= '0;
      end
      if (w_xfer) begin
        r_acc <= w_add[31:0];
        r_cnt <= r_cnt + 1'b1;
        if (w_add[32]) r_fpx <= 1'b1;
      end
      if (r_state == COMPARE) begin
        r_np    <= w_fire ? V_RESET : r_acc;
        r_spike <= w_fire;
        r_npv   <= 1'b1;
      end
    end
  end

  assign bus.weight_ready        = w_ready;
  assign bus.new_potential       = r_np;
  assign bus.new_potential_valid = r_npv;
  assign bus.spike               = r_spike;
  assign bus.input_count         = r_cnt;
  assign bus.busy                = (r_state != IDLE);
  assign bus.fp_exception        = r_fpx;
  assign bus.protocol_err        = r_perr;
endmodule

// File: tb/tb_potential_adder_threshold.sv
// Directed bench for the potential adder/threshold block.
module tb_potential_adder_threshold;
  logic CLK, RST;
  int   n_assert, n_fail;

  potential_adder_threshold_if #(.MAX_INPUTS(16)) bus ();

  potential_adder_threshold #(
    .THRESHOLD(32'h41F00000), .V_RESET(32'h00000000), .MAX_INPUTS(16)
  ) dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.decay_valid = 1'b0; bus.decayed_potential = 32'd0;
    bus.weight_valid = 1'b0; bus.weight = 32'd0; bus.step_end = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    cyc(); cyc();
    RST = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    bus.decay_valid = 1'b1; bus.decayed_potential = v;
    cyc();
    bus.decay_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    #2;
    n_assert++; if (bus.new_potential !== 32'd0) begin n_fail++; $display("FAIL rst_np got %h want 00000000", bus.new_potential); end
    n_assert++; if ({bus.new_potential_valid, bus.spike, bus.weight_ready, bus.busy, bus.fp_exception, bus.protocol_err} !== 6'd0) begin n_fail++; $display("FAIL rst_flags got %b want 000000", {bus.new_potential_valid, bus.spike, bus.weight_ready, bus.busy, bus.fp_exception, bus.protocol_err}); end
    n_assert++; if (bus.input_count !== 5'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.input_count); end
    cyc(); cyc();
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_no_fire();
    load(32'h41DED852);
    n_assert++; if ({bus.busy, bus.weight_ready} !== 2'b11) begin n_fail++; $display("FAIL nf_accum busy/ready got %b want 11", {bus.busy, bus.weight_ready}); end
    bus.weight_valid = 1'b1; bus.weight = 32'h3F800000;
    cyc(); cyc();
    bus.weight_valid = 1'b0; bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    n_assert++; if ({bus.busy, bus.weight_ready, bus.new_potential_valid} !== 3'b100) begin n_fail++; $display("FAIL nf_compare busy/ready/valid got %b want 100", {bus.busy, bus.weight_ready, bus.new_potential_valid}); end
    cyc();
    n_assert++; if (bus.new_potential_valid !== 1'b1) begin n_fail++; $display("FAIL nf_valid got %b want 1", bus.new_potential_valid); end
    n_assert++; if (bus.new_potential !== 32'h41EED852) begin n_fail++; $display("FAIL nf_np got %h want 41eed852", bus.new_potential); end
    n_assert++; if (bus.spike !== 1'b0) begin n_fail++; $display("FAIL nf_spike got %b want 0", bus.spike); end
    n_assert++; if (bus.input_count !== 5'd2) begin n_fail++; $display("FAIL nf_cnt got %0d want 2", bus.input_count); end
    cyc();
    n_assert++; if (bus.new_potential_valid !== 1'b0) begin n_fail++; $display("FAIL nf_valid_clear got %b want 0", bus.new_potential_valid); end
    n_assert++; if (bus.new_potential !== 32'h41EED852) begin n_fail++; $display("FAIL nf_np_hold got %h want 41eed852", bus.new_potential); end
  endtask

  task automatic test_fire_back_to_back();
    load(32'h41DED852);
    bus.weight_valid = 1'b1; bus.weight = 32'h3F800000;
    cyc(); cyc(); cyc();
    bus.weight_valid = 1'b0; bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.new_potential_valid, bus.spike} !== 2'b11) begin n_fail++; $display("FAIL fire_valid/spike got %b want 11", {bus.new_potential_valid, bus.spike}); end
    n_assert++; if (bus.new_potential !== 32'h00000000) begin n_fail++; $display("FAIL fire_np got %h want 00000000", bus.new_potential); end
    load(32'h3F800000);
    n_assert++; if ({bus.busy, bus.new_potential_valid, bus.spike} !== 3'b100) begin n_fail++; $display("FAIL b2b_load busy/valid/spike got %b want 100", {bus.busy, bus.new_potential_valid, bus.spike}); end
    bus.weight_valid = 1'b1; bus.weight = 32'h3F800000;
    cyc();
    bus.weight_valid = 1'b0; bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if (bus.new_potential !== 32'h40000000) begin n_fail++; $display("FAIL b2b_np got %h want 40000000", bus.new_potential); end
    cyc();
  endtask

  task automatic test_saturation();
    int acc;
    acc = 0;
    load(32'h00000000);
    bus.weight_valid = 1'b1; bus.weight = 32'h3F800000;
    for (int i = 0; i < 20; i++) begin
      if (bus.weight_ready === 1'b1) acc++;
      cyc();
    end
    n_assert++; if (acc !== 16) begin n_fail++; $display("FAIL sat_accepted got %0d want 16", acc); end
    n_assert++; if (bus.input_count !== 5'd16) begin n_fail++; $display("FAIL sat_cnt got %0d want 16", bus.input_count); end
    n_assert++; if (bus.weight_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready got %b want 0", bus.weight_ready); end
    bus.weight_valid = 1'b0; bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.new_potential, bus.spike} !== {32'h41800000, 1'b0}) begin n_fail++; $display("FAIL sat_np/spike got %h/%b want 41800000/0", bus.new_potential, bus.spike); end
    cyc();
  endtask

  task automatic test_same_cycle();
    load(32'h41F00000);
    bus.weight_valid = 1'b1; bus.weight = 32'hBF800000; bus.step_end = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    n_assert++; if ({bus.new_potential, bus.spike} !== {32'h41E80000, 1'b0}) begin n_fail++; $display("FAIL same_np/spike got %h/%b want 41e80000/0", bus.new_potential, bus.spike); end
    n_assert++; if (bus.input_count !== 5'd1) begin n_fail++; $display("FAIL same_cnt got %0d want 1", bus.input_count); end
    cyc();
  endtask

  task automatic test_threshold_edges();
    load(32'h41F00000);
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.spike, bus.new_potential} !== {1'b1, 32'h00000000}) begin n_fail++; $display("FAIL equal_thr spike/np got %b/%h want 1/00000000", bus.spike, bus.new_potential); end
    load(32'hC2000000);
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.spike, bus.new_potential} !== {1'b0, 32'hC2000000}) begin n_fail++; $display("FAIL negative spike/np got %b/%h want 0/c2000000", bus.spike, bus.new_potential); end
    load(32'h7FC00001);
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.spike, bus.new_potential} !== {1'b0, 32'h7FC00001}) begin n_fail++; $display("FAIL nan spike/np got %b/%h want 0/7fc00001", bus.spike, bus.new_potential); end
    cyc();
  endtask

  task automatic test_fp_exception();
    n_assert++; if (bus.fp_exception !== 1'b0) begin n_fail++; $display("FAIL fpx_before got %b want 0", bus.fp_exception); end
    load(32'h3F800000);
    bus.weight_valid = 1'b1; bus.weight = 32'h7F800000;
    cyc();
    bus.weight_valid = 1'b0;
    n_assert++; if (bus.fp_exception !== 1'b1) begin n_fail++; $display("FAIL fpx_set got %b want 1", bus.fp_exception); end
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc(); cyc();
    n_assert++; if (bus.fp_exception !== 1'b1) begin n_fail++; $display("FAIL fpx_sticky got %b want 1", bus.fp_exception); end
  endtask

  task automatic test_protocol();
    int extra;
    do_reset();
    n_assert++; if ({bus.fp_exception, bus.protocol_err} !== 2'b00) begin n_fail++; $display("FAIL prot_rst got %b want 00", {bus.fp_exception, bus.protocol_err}); end
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if ({bus.protocol_err, bus.busy, bus.new_potential_valid} !== 3'b100) begin n_fail++; $display("FAIL prot_idle_step err/busy/valid got %b want 100", {bus.protocol_err, bus.busy, bus.new_potential_valid}); end
    do_reset();
    load(32'h41DED852);
    bus.weight_valid = 1'b1; bus.weight = 32'h3F800000;
    cyc();
    bus.weight_valid = 1'b0;
    n_assert++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("FAIL prot_clean got %b want 0", bus.protocol_err); end
    load(32'h40000000);
    n_assert++; if ({bus.protocol_err, bus.input_count} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL prot_decay err/cnt got %b/%0d want 1/1", bus.protocol_err, bus.input_count); end
    bus.step_end = 1'b1;
    cyc();
    bus.step_end = 1'b0;
    cyc();
    n_assert++; if (bus.new_potential !== 32'h41E6D852) begin n_fail++; $display("FAIL prot_acc got %h want 41e6d852", bus.new_potential); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.new_potential_valid === 1'b1) extra++;
    end
    n_assert++; if ((extra !== 0) || (bus.protocol_err !== 1'b1)) begin n_fail++; $display("FAIL prot_after extra=%0d err=%b want 0/1", extra, bus.protocol_err); end
  endtask

  task automatic test_reset_mid_accum();
    load(32'h41DED852);
    bus.weight_valid = 1'b1; bus.weight = 32'h7F800000;
    cyc();
    bus.weight = 32'h3F800000;
    #2;
    RST = 1'b1;
    #1;
    n_assert++; if ({bus.busy, bus.weight_ready, bus.fp_exception, bus.protocol_err, bus.input_count} !== 9'd0) begin n_fail++; $display("FAIL mid_rst busy/ready/fpx/err/cnt got %b want 0", {bus.busy, bus.weight_ready, bus.fp_exception, bus.protocol_err, bus.input_count}); end
    n_assert++; if ({bus.new_potential, bus.new_potential_valid, bus.spike} !== 34'd0) begin n_fail++; $display("FAIL mid_rst np/valid/spike got %h/%b/%b want 0", bus.new_potential, bus.new_potential_valid, bus.spike); end
    cyc();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_assert++; if ({bus.new_potential_valid, bus.busy, bus.weight_ready} !== 3'b000) begin n_fail++; $display("FAIL mid_after%0d valid/busy/ready got %b want 000", i, {bus.new_potential_valid, bus.busy, bus.weight_ready}); end
    end
    idle_inputs();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_no_fire();
    test_fire_back_to_back();
    test_saturation();
    test_same_cycle();
    test_threshold_edges();
    test_fp_exception();
    test_protocol();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
